instr_seq_ctrl: RTL

- Parametrised, sequential successor to the combinational opcode decoder.
- Accepts instructions over a valid/ready handshake and issues registered control pulses to the ALU datapath.
- Owns the multi-cycle opcodes: WAIT runs a programmable countdown; LDSW runs a load request/acknowledge handshake.
- Sits between instruction fetch and the ALU/register-enable logic; ALU register-enable width scales with NUM_ALU_REGS.

---
 rtl/instr_seq_ctrl_pkg.sv | 30 +++
 rtl/instr_seq_ctrl_if.sv | 44 ++++
 rtl/instr_seq_ctrl_decode.sv | 50 +++++
 rtl/instr_seq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/instr_seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer.
//   - Opcode values for the {opcode, operand} instruction word.
//   - Sequencer state encoding.
//   - Decoded control flags. The register-enable vector is sized by
//     NUM_ALU_REGS, so each module that needs it adds that vector itself.
package instr_seq_pkg;

  localparam int OP_MOV  = 0;
  localparam int OP_MAC  = 1;
  localparam int OP_WAIT = 2;
  localparam int OP_SETB = 3;
  localparam int OP_SETD = 4;
  localparam int OP_SETE = 5;
  localparam int OP_LDSW = 6;
  localparam int OP_SETR = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2
  } state_e;

  typedef struct packed {
    logic f_add;
    logic wr_res;
    logic is_wait;
    logic is_load;
  } ctrl_flags_t;

endpackage

// File: rtl/instr_seq_ctrl_if.sv
// Bus between instruction fetch / ALU datapath and instr_seq_ctrl.
//   slave  : the sequencer side (takes instructions and ld_ack, drives controls)
//   master : the fetch/datapath side
// Optional macro INSTR_SEQ_ILLEGAL_TRAP_EN adds the sticky illegal_err flag.
interface instr_seq_ctrl_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int OPERAND_W    = 8,
  parameter int NUM_ALU_REGS = 3
);
  logic                              instr_valid;
  logic                              instr_ready;
  logic [OPCODE_WIDTH+OPERAND_W-1:0] instr;
  logic                              f_add;
  logic                              f_wait;
  logic                              f_load;
  logic                              wr_res;
  logic [NUM_ALU_REGS-1:0]           alu_reg_en;
  logic [OPERAND_W-1:0]              operand_q;
  logic                              ld_req;
  logic                              ld_ack;
  logic                              busy;
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
  logic                              illegal_err;
`endif

  modport slave (
    input  instr_valid, instr, ld_ack,
    output instr_ready, f_add, f_wait, f_load, wr_res, alu_reg_en,
           operand_q, ld_req, busy
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
    , output illegal_err
`endif
  );

  modport master (
    output instr_valid, instr, ld_ack,
    input  instr_ready, f_add, f_wait, f_load, wr_res, alu_reg_en,
           operand_q, ld_req, busy
`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
    , input illegal_err
`endif
  );

endinterface

// File: rtl/instr_seq_ctrl_decode.sv
// Purely combinational opcode/operand decoder for instr_seq_ctrl.
//   opcode, operand : fields of the instruction word
//   flags           : f_add / wr_res for single-cycle ops, is_wait / is_load
//                     for the multi-cycle ops the sequencer FSM owns
//   reg_en          : per-register ALU load enables
//   legal           : 0 for undefined opcodes and out-of-range SETR indexes
module instr_seq_decode
  import instr_seq_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int OPERAND_W    = 8,
  parameter int NUM_ALU_REGS = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [OPERAND_W-1:0]    operand,
  output ctrl_flags_t             flags,
  output logic [NUM_ALU_REGS-1:0] reg_en,
  output logic                    legal
);

  localparam logic [NUM_ALU_REGS-1:0] REG_EN_ONE = NUM_ALU_REGS'(1);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of latches.
    flags  = '0;
    reg_en = '0;
    legal  = 1'b1;
    case (int'(opcode))
      OP_MOV: begin
        flags.f_add  = 1'b1;
        flags.wr_res = 1'b1;
        reg_en       = '1;
      end
      OP_MAC:  flags.wr_res  = 1'b1;
      OP_WAIT: flags.is_wait = 1'b1;
      OP_SETB: reg_en = REG_EN_ONE;
      OP_SETD: reg_en = REG_EN_ONE << 1;
      OP_SETE: reg_en = REG_EN_ONE << 2;
      OP_LDSW: flags.is_load = 1'b1;
      OP_SETR: begin
        // Widen both sides so the range test holds for any operand width.
        if (64'(operand) < 64'(NUM_ALU_REGS)) reg_en = REG_EN_ONE << operand;
        else                                  legal  = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_seq_ctrl.sv
// Sequential instruction controller between fetch and the ALU datapath.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : instr_seq_ctrl_if.slave -- valid/ready instruction input,
//              registered one-cycle control pulses, WAIT indicator, load
//              request/acknowledge handshake, busy and last operand.
// Single-cycle ops issue one cycle after accept; WAIT counts down its
// operand; LDSW holds ld_req until ld_ack.
// Optional macro INSTR_SEQ_ILLEGAL_TRAP_EN: sticky illegal_err that halts
// instruction acceptance until reset.
module instr_seq_ctrl
  import instr_seq_pkg::*;
#(
  parameter int OPCODE_WIDTH = 3,
  parameter int OPERAND_W    = 8,
  parameter int NUM_ALU_REGS = 3
) (
  input logic              clk,
  input logic              rst,
  instr_seq_ctrl_if.slave  bus
);

  typedef struct packed {
    logic                    f_add;
    logic                    wr_res;
    logic                    f_load;
    logic [NUM_ALU_REGS-1:0] reg_en;
  } issue_t;

  state_e                  state_q, state_d;
  logic [OPERAND_W-1:0]    cnt_q, cnt_d;
  logic [OPERAND_W-1:0]    operand_q, operand_d;
  issue_t                  issue_q, issue_d;
  logic                    instr_ready;
  logic                    accept;
  ctrl_flags_t             dec_flags;
  logic [NUM_ALU_REGS-1:0] dec_reg_en;
  logic                    dec_legal;

  instr_seq_decode #(
    .OPCODE_WIDTH (OPCODE_WIDTH),
    .OPERAND_W    (OPERAND_W),
    .NUM_ALU_REGS (NUM_ALU_REGS)
  ) u_decode (
    .opcode  (bus.instr[OPCODE_WIDTH+OPERAND_W-1:OPERAND_W]),
    .operand (bus.instr[OPERAND_W-1:0]),
    .flags   (dec_flags),
    .reg_en  (dec_reg_en),
    .legal   (dec_legal)
  );

`ifdef INSTR_SEQ_ILLEGAL_TRAP_EN
  logic illegal_err_q, illegal_err_d;

  assign illegal_err_d = illegal_err_q | (accept & ~dec_legal);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_err_q <= 1'b0;
    else     illegal_err_q <= illegal_err_d;
  end

  // A trapped block stops taking instructions until reset.
  assign instr_ready     = (state_q == ST_IDLE) && !illegal_err_q;
  assign bus.illegal_err = illegal_err_q;
`else
  // Illegal instructions are silent NOPs; legality is not needed here.
  logic unused_legal;
  assign unused_legal = dec_legal;
  assign instr_ready  = (state_q == ST_IDLE);
`endif

  // Ready depends on state only, never on instr_valid.
  assign accept = bus.instr_valid && instr_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    issue_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          operand_d      = bus.instr[OPERAND_W-1:0];
          issue_d.f_add  = dec_flags.f_add;
          issue_d.wr_res = dec_flags.wr_res;
          issue_d.reg_en = dec_reg_en;
          if (dec_flags.is_wait) begin
            state_d = ST_WAIT;
            cnt_d   = bus.instr[OPERAND_W-1:0];
          end else if (dec_flags.is_load) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_WAIT: begin
        // Exit on the cycle the counter reads zero: N+1 WAIT cycles total.
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - OPERAND_W'(1);
      end
      ST_LOAD: begin
        if (bus.ld_ack) begin
          state_d        = ST_IDLE;
          issue_d.f_load = 1'b1;
          issue_d.f_add  = 1'b1;
          issue_d.wr_res = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      operand_q <= '0;
      issue_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      issue_q   <= issue_d;
    end
  end

  // f_wait and ld_req come straight from the state register, so reset drops
  // them immediately.
  assign bus.instr_ready = instr_ready;
  assign bus.f_add       = issue_q.f_add;
  assign bus.wr_res      = issue_q.wr_res;
  assign bus.f_load      = issue_q.f_load;
  assign bus.alu_reg_en  = issue_q.reg_en;
  assign bus.operand_q   = operand_q;
  assign bus.f_wait      = (state_q == ST_WAIT);
  assign bus.ld_req      = (state_q == ST_LOAD);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
